// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use bubbles, taken-branch flushes,
// data-memory freeze, plus saturating stall/flush performance counters.
module hazard_ctrl #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned LU_BUBBLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_rd,
   input  logic [4:0]       IFID_rs1,
   input  logic [4:0]       IFID_rs2,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             EXMEM_flush,
   output logic             freeze,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StLuStall = 2'b01,
      StMemWait = 2'b10
   } state_e;

   localparam logic [1:0] LuInit = 2'(LU_BUBBLES - 1);

   state_e           state_q, state_d, eff_state;
   logic [1:0]       bub_q, bub_d;
   logic             lu, flush_evt;
   logic [CNT_W-1:0] stall_q, flush_q;

   assign lu = IDEX_MemRead && (IDEX_rd != 5'd0) &&
               ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));

   // MEM_WAIT resumes whichever state was interrupted, recovered from the bubble count.
   always_comb begin
      if (state_q == StMemWait) begin
         eff_state = (bub_q != 2'd0) ? StLuStall : StRun;
      end else begin
         eff_state = state_q;
      end
   end

   always_comb begin
      PC_Write    = 1'b1;
      IFID_Write  = 1'b1;
      IFID_flush  = 1'b0;
      IDEX_flush  = 1'b0;
      EXMEM_flush = 1'b0;
      freeze      = 1'b0;
      flush_evt   = 1'b0;
      state_d     = state_q;
      bub_d       = bub_q;
      if (reset) begin
         state_d = StRun;
         bub_d   = 2'd0;
      end else if (mem_busy) begin
         freeze     = 1'b1;
         PC_Write   = 1'b0;
         IFID_Write = 1'b0;
         state_d    = StMemWait;
      end else if (branch_taken) begin
         IFID_flush  = 1'b1;
         IDEX_flush  = 1'b1;
         EXMEM_flush = 1'b1;
         flush_evt   = 1'b1;
         state_d     = StRun;
         bub_d       = 2'd0;
      end else begin
         unique case (eff_state)
            StLuStall: begin
               PC_Write   = 1'b0;
               IFID_Write = 1'b0;
               IDEX_flush = 1'b1;
               bub_d      = bub_q - 2'd1;
               state_d    = (bub_q == 2'd1) ? StRun : StLuStall;
            end
            default: begin
               state_d = StRun;
               if (lu) begin
                  PC_Write   = 1'b0;
                  IFID_Write = 1'b0;
                  IDEX_flush = 1'b1;
                  bub_d      = LuInit;
                  state_d    = (LuInit != 2'd0) ? StLuStall : StRun;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StRun;
         bub_q   <= 2'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
         if (!PC_Write && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         if (flush_evt && (flush_q != {CNT_W{1'b1}})) begin
            flush_q <= flush_q + CNT_W'(1);
         end
      end
   end

   assign state_o   = state_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two hazard_ctrl instances (A: LU_BUBBLES=1, CNT_W=4; B: LU_BUBBLES=3,
// CNT_W=16) driven one at a time by directed vectors; a monitor checks at each negedge.
module tb_hazard_ctrl;

   localparam logic [5:0] IDLE = 6'b110000;  // {PCW, IFIDW, IFIDf, IDEXf, EXMEMf, freeze}
   localparam logic [5:0] STL  = 6'b000100;
   localparam logic [5:0] BRF  = 6'b111110;
   localparam logic [5:0] FRZ  = 6'b000001;

   typedef struct {
      bit         sel_a;
      bit         chk;
      logic [5:0] ctl;
      int         st;
      int         sc;
      int         fc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst = 1'b1, a_mr = 1'b0, a_br = 1'b0, a_busy = 1'b0;
   logic [4:0] a_rd = '0, a_rs1 = '0, a_rs2 = '0;
   logic       b_rst = 1'b1, b_mr = 1'b0, b_br = 1'b0, b_busy = 1'b0;
   logic [4:0] b_rd = '0, b_rs1 = '0, b_rs2 = '0;

   logic        a_pcw, a_ifw, a_iff, a_idf, a_emf, a_frz;
   logic [1:0]  a_st;
   logic [3:0]  a_sc, a_fc;
   logic        b_pcw, b_ifw, b_iff, b_idf, b_emf, b_frz;
   logic [1:0]  b_st;
   logic [15:0] b_sc, b_fc;

   hazard_ctrl #(.CNT_W(4), .LU_BUBBLES(1)) dut_a (
      .clk(clk), .reset(a_rst), .IDEX_MemRead(a_mr), .IDEX_rd(a_rd), .IFID_rs1(a_rs1),
      .IFID_rs2(a_rs2), .branch_taken(a_br), .mem_busy(a_busy), .PC_Write(a_pcw),
      .IFID_Write(a_ifw), .IFID_flush(a_iff), .IDEX_flush(a_idf), .EXMEM_flush(a_emf),
      .freeze(a_frz), .state_o(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc)
   );

   hazard_ctrl #(.CNT_W(16), .LU_BUBBLES(3)) dut_b (
      .clk(clk), .reset(b_rst), .IDEX_MemRead(b_mr), .IDEX_rd(b_rd), .IFID_rs1(b_rs1),
      .IFID_rs2(b_rs2), .branch_taken(b_br), .mem_busy(b_busy), .PC_Write(b_pcw),
      .IFID_Write(b_ifw), .IFID_flush(b_iff), .IDEX_flush(b_idf), .EXMEM_flush(b_emf),
      .freeze(b_frz), .state_o(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc)
   );

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   vec   = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s (vector %0d): got %0d, expected %0d", name, vec, act, req);
      end
   endtask

   // Monitor: outputs are always present, so one expected entry is consumed per cycle.
   initial begin
      exp_t       e;
      logic [5:0] ctl;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            vec++;
            if (e.chk) begin
               if (e.sel_a) begin
                  ctl = {a_pcw, a_ifw, a_iff, a_idf, a_emf, a_frz};
                  check("A_ctl", int'(ctl), int'(e.ctl));
                  check("A_state", int'(a_st), e.st);
                  check("A_stall_cnt", int'(a_sc), e.sc);
                  check("A_flush_cnt", int'(a_fc), e.fc);
               end else begin
                  ctl = {b_pcw, b_ifw, b_iff, b_idf, b_emf, b_frz};
                  check("B_ctl", int'(ctl), int'(e.ctl));
                  check("B_state", int'(b_st), e.st);
                  check("B_stall_cnt", int'(b_sc), e.sc);
                  check("B_flush_cnt", int'(b_fc), e.fc);
               end
            end
         end
      end
   end

   // Drive one cycle to the selected DUT (the other is held in reset) and queue its expectation.
   task automatic drv(input bit sel_a, input bit rst, input bit mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input bit br,
                      input bit busy, input bit chk, input logic [5:0] ctl, input int st,
                      input int sc, input int fc);
      exp_t e;
      @(posedge clk);
      #1;
      if (sel_a) begin
         a_rst = rst; a_mr = mr; a_rd = rd; a_rs1 = rs1; a_rs2 = rs2; a_br = br; a_busy = busy;
         b_rst = 1'b1; b_mr = 1'b0; b_br = 1'b0; b_busy = 1'b0;
      end else begin
         b_rst = rst; b_mr = mr; b_rd = rd; b_rs1 = rs1; b_rs2 = rs2; b_br = br; b_busy = busy;
         a_rst = 1'b1; a_mr = 1'b0; a_br = 1'b0; a_busy = 1'b0;
      end
      e.sel_a = sel_a; e.chk = chk; e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc;
      sb.push_back(e);
   endtask

   initial begin
      // ---- DUT B: LU_BUBBLES=3 ----
      //  sel rst mr rd  rs1 rs2 br busy chk ctl   st sc fc
      drv(0, 1, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0, 0);
      drv(0, 1, 1, 5, 5, 0, 0, 0, 1, IDLE, 0, 0, 0);   // reset masks lu
      drv(0, 0, 1, 0, 0, 0, 0, 0, 1, IDLE, 0, 0, 0);   // rd=x0
      drv(0, 0, 1, 7, 3, 4, 0, 0, 1, IDLE, 0, 0, 0);   // no match
      drv(0, 0, 1, 5, 5, 0, 0, 0, 1, STL,  0, 0, 0);   // bubble 1
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, STL,  1, 1, 0);   // bubble 2
      drv(0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ,  1, 2, 0);   // freeze x4
      drv(0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ,  2, 3, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ,  2, 4, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ,  2, 5, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, STL,  2, 6, 0);   // bubble 3
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 7, 0);
      drv(0, 0, 0, 0, 0, 0, 1, 0, 1, BRF,  0, 7, 0);   // branch
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 7, 1);
      drv(0, 0, 1, 5, 0, 5, 1, 0, 1, BRF,  0, 7, 1);   // branch beats lu
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 7, 2);
      drv(0, 0, 0, 0, 0, 0, 1, 1, 1, FRZ,  0, 7, 2);   // busy beats branch
      drv(0, 0, 0, 0, 0, 0, 1, 0, 1, BRF,  2, 8, 2);   // flush after busy falls
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 8, 3);
      drv(0, 0, 1, 9, 9, 0, 0, 0, 1, STL,  0, 8, 3);   // lu
      drv(0, 0, 0, 0, 0, 0, 1, 0, 1, BRF,  1, 9, 3);   // branch aborts LU_STALL
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 9, 4);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ,  0, 9, 4);
      drv(0, 1, 0, 0, 0, 0, 0, 1, 1, IDLE, 2, 10, 4);  // reset in MEM_WAIT
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 0, 0);
      // ---- DUT A: LU_BUBBLES=1, CNT_W=4 ----
      drv(1, 1, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0, 0);
      drv(1, 1, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 0, 0);
      drv(1, 0, 1, 5, 1, 5, 0, 0, 1, STL,  0, 0, 0);   // single bubble
      drv(1, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 1, 0);
      for (int i = 0; i < 16; i++) begin
         drv(1, 0, 0, 0, 0, 0, 0, 1, 1, FRZ, (i == 0) ? 0 : 2, (i + 1 > 15) ? 15 : i + 1, 0);
      end
      drv(1, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 2, 15, 0);  // stall_cnt saturated
      for (int i = 0; i < 17; i++) begin
         drv(1, 0, 0, 0, 0, 0, 1, 0, 1, BRF, 0, 15, (i > 15) ? 15 : i);
      end
      drv(1, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 15, 15); // flush_cnt saturated
      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
